instr_fetch_ctrl: RTL and testbench

Sequencing controller on the consuming side of the program counter: drives the counter's clear and increment controls, takes the instruction word returned by the synchronous instruction ROM at the current address, and presents it to the datapath under a valid/done handshake. It sits between the program counter, the instruction ROM and the datapath control unit in the 16-bit processor. It also determines when the program has finished, either on a HALT opcode or at the last ROM address.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/instr_fetch_ctrl.sv | 85 ++++++++
 tb/tb_instr_fetch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit processor.
// Fetch controller states, bus widths and opcode field layout.
package cpu_pkg;

  localparam int ADDR_W  = 7;
  localparam int INSTR_W = 16;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;

  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EXEC,
    ADVANCE,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: steps the PC, latches ROM words into IR and
// hands them to the datapath until HALT or the last ROM address.
module instr_fetch_ctrl
  import cpu_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic [INSTR_W-1:0] ROM_Data,
  input  logic               Exec_Done,
  output logic               PC_Clr,
  output logic               PC_Up,
  output logic [INSTR_W-1:0] IR,
  output logic               Instr_Valid,
  output logic               Halted
);

  fetch_state_t state;
  fetch_state_t state_nx;

  logic is_halt;
  logic last_addr;

  assign is_halt   = (IR[OP_MSB:OP_LSB] == OP_HALT);
  assign last_addr = &Addr;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      IR    <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        IR <= ROM_Data;
      end
    end
  end

  // Stopping at the last address keeps the PC from wrapping to 0.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (Start) state_nx = FETCH;
      end
      FETCH: begin
        state_nx = LOAD;
      end
      LOAD: begin
        state_nx = EXEC;
      end
      EXEC: begin
        if (Exec_Done) begin
          if (is_halt || last_addr) state_nx = HALTED;
          else                      state_nx = ADVANCE;
        end
      end
      ADVANCE: begin
        state_nx = FETCH;
      end
      HALTED: begin
        if (Start) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    PC_Clr      = 1'b0;
    PC_Up       = 1'b0;
    Instr_Valid = 1'b0;
    Halted      = 1'b0;
    unique case (state)
      IDLE:    PC_Clr      = 1'b1;
      EXEC:    Instr_Valid = 1'b1;
      ADVANCE: PC_Up       = 1'b1;
      HALTED:  Halted      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl with PC and registered ROM models,
// a program-level reference and a scoreboard monitor.
module tb_instr_fetch_ctrl;

  localparam int AW = 7;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          exec_done = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [IW-1:0] rom_data = '0;
  logic          pc_clr;
  logic          pc_up;
  logic [IW-1:0] ir;
  logic          valid;
  logic          halted;

  logic [IW-1:0] mem [0:127];

  typedef struct {
    int          a;
    logic [15:0] w;
  } exp_t;

  exp_t exp_q [$];
  int   halt_q [$];

  int passed = 0;
  int total = 0;
  int pcup_cnt = 0;
  bit ed_auto = 1'b0;
  int ed_pct = 100;

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .Clk        (clk),
    .Reset      (reset),
    .Start      (start),
    .Addr       (addr),
    .ROM_Data   (rom_data),
    .Exec_Done  (exec_done),
    .PC_Clr     (pc_clr),
    .PC_Up      (pc_up),
    .IR         (ir),
    .Instr_Valid(valid),
    .Halted     (halted)
  );

  // Program counter and synchronous ROM living beside the controller.
  always @(posedge clk) begin
    if (pc_clr)     addr <= '0;
    else if (pc_up) addr <= addr + 1'b1;
    rom_data <= mem[addr];
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // which: 0 waits for Instr_Valid, 1 waits for Halted.
  task automatic wait_sig(input int which, input int maxc, output int n);
    n = 0;
    while (!(which == 0 ? valid : halted) && n < maxc) begin
      tick();
      n++;
    end
    if (n >= maxc) begin
      if (which == 0) check("timeout_valid", valid, 1);
      else            check("timeout_halted", halted, 1);
    end
  endtask

  // Reference: the program runs word by word from address 0 until
  // a HALT opcode or the last address, where it stops.
  task automatic build_expect();
    exp_t e;
    int   a;
    a = 0;
    while (1) begin
      e.a = a;
      e.w = mem[a];
      exp_q.push_back(e);
      if (mem[a][15:12] == 4'hF || a == 127) break;
      a++;
    end
    halt_q.push_back(a);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_from_idle();
    build_expect();
    pulse_start();
  endtask

  task automatic restart_from_halted();
    pulse_start();
    check("restart_halted_low", halted, 0);
    check("restart_pc_clr", pc_clr, 1);
    tick();
    check("restart_addr0", addr, 0);
    run_from_idle();
  endtask

  task automatic fill_random(input int halt_odds);
    for (int i = 0; i < 128; i++) begin
      if (halt_odds > 0 && $urandom_range(halt_odds - 1) == 0)
        mem[i] = {4'hF, 12'($urandom)};
      else
        mem[i] = {4'($urandom_range(14)), 12'($urandom)};
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (ed_auto) exec_done = (int'($urandom_range(99)) < ed_pct);
    end
  end

  initial begin
    bit          pv;
    bit          ph;
    logic [15:0] cur;
    exp_t        e;
    int          h;
    pv = 1'b0;
    ph = 1'b0;
    cur = '0;
    forever begin
      tick();
      if (reset) begin
        pv = 1'b0;
        ph = 1'b0;
      end else begin
        if (pc_up) pcup_cnt++;
        check("clr_up_exclusive", {31'd0, pc_clr & pc_up}, 0);
        if (valid && !pv) begin
          if (exp_q.size() == 0) begin
            check("unexpected_instr", valid, 0);
          end else begin
            e = exp_q.pop_front();
            check("sb_ir", ir, e.w);
            check("sb_addr", addr, e.a);
          end
          cur = ir;
        end else if (valid) begin
          check("ir_hold", ir, cur);
        end
        if (halted && !ph) begin
          if (halt_q.size() == 0) begin
            check("unexpected_halt", halted, 0);
          end else begin
            h = halt_q.pop_front();
            check("halt_addr", addr, h);
          end
        end
        pv = valid;
        ph = halted;
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int c0;
    logic [15:0] cur;

    for (int i = 0; i < 128; i++) mem[i] = '0;

    tick();
    tick();
    check("rst_pc_clr", pc_clr, 1);
    check("rst_ir", ir, 0);
    check("rst_valid", valid, 0);
    check("rst_halted", halted, 0);
    check("rst_pc_up", pc_up, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("idle_holds", pc_clr, 1);

    mem[0] = 16'h1234;
    mem[1] = 16'h2345;
    mem[2] = 16'hF000;
    ed_auto = 1'b1;
    ed_pct = 100;
    run_from_idle();
    check("start_edge_valid", valid, 0);
    wait_sig(0, 10, n);
    check("start_to_valid", n, 2);
    check("first_ir", ir, 16'h1234);
    c0 = pcup_cnt;
    tick();
    check("advance_valid_low", valid, 0);
    wait_sig(0, 10, n);
    check("instr_period", n + 1, 4);
    check("second_ir", ir, 16'h2345);
    check("one_pc_up", pcup_cnt - c0, 1);
    wait_sig(1, 20, n);

    for (int i = 0; i < 3; i++) mem[i] = {4'($urandom_range(14)), 12'($urandom)};
    mem[3] = 16'hF000;
    ed_auto = 1'b0;
    exec_done = 1'b0;
    restart_from_halted();
    wait_sig(0, 10, n);
    c0 = pcup_cnt;
    cur = ir;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", valid, 1);
      check("stall_ir", ir, cur);
    end
    pulse_start();
    check("start_in_exec", valid, 1);
    check("stall_no_up", pcup_cnt - c0, 0);
    @(negedge clk);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    check("done_drops_valid", valid, 0);
    check("done_pc_up", pc_up, 1);
    tick();
    check("pc_up_one_cycle", pc_up, 0);
    check("single_pc_up", pcup_cnt - c0, 1);
    ed_auto = 1'b1;
    ed_pct = 50;
    wait_sig(1, 200, n);
    check("halt3_addr", addr, 3);
    ed_pct = 100;
    repeat (8) tick();
    check("halt_sticky", halted, 1);
    check("halt_addr_kept", addr, 3);
    check("halt_no_valid", valid, 0);

    ed_auto = 1'b0;
    exec_done = 1'b0;
    restart_from_halted();
    wait_sig(0, 10, n);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_valid", valid, 0);
    check("async_rst_clr", pc_clr, 1);
    check("async_rst_ir", ir, 0);
    exp_q.delete();
    halt_q.delete();
    @(negedge clk);
    reset = 1'b0;

    fill_random(0);
    ed_auto = 1'b1;
    ed_pct = 70;
    run_from_idle();
    wait_sig(1, 3000, n);
    check("end_addr", addr, 127);
    check("end_q_empty", exp_q.size(), 0);
    repeat (5) tick();
    check("no_wrap", addr, 127);
    check("end_halted", halted, 1);

    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        fill_random(0);
        mem[127] = 16'hF123;
      end else begin
        fill_random(12);
      end
      ed_pct = 40 + 20 * k;
      restart_from_halted();
      wait_sig(1, 4000, n);
      check("rand_q_empty", exp_q.size(), 0);
    end

    tick();
    check("halt_q_empty", halt_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
